// File: rtl/conv_fetch_seq.sv
// Convolution fetch sequencer: walks oc/oy/ox/group/ky/kx, issues one data and one weight
// burst per tap and presents the deserialized PARA-lane vector pair to the CMAC array.
module conv_fetch_seq #(
  parameter int DATA_W = 16,
  parameter int PARA   = 16,
  parameter int ADDR_W = 30,
  parameter int SIDE_W = 8,
  parameter int CH_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [SIDE_W-1:0]      kernel,
  input  logic [3:0]             stride,
  input  logic [1:0]             pad,
  input  logic [CH_W-1:0]        i_channel,
  input  logic [CH_W-1:0]        o_channel,
  input  logic [SIDE_W-1:0]      i_side,
  input  logic [SIDE_W-1:0]      o_side,
  input  logic [ADDR_W-1:0]      data_base,
  input  logic [ADDR_W-1:0]      weight_base,
  output logic                   d_req,
  output logic [ADDR_W-1:0]      d_addr,
  output logic [CH_W-1:0]        d_len,
  input  logic                   d_ack,
  input  logic                   d_we,
  input  logic [DATA_W-1:0]      d_data,
  output logic                   w_req,
  output logic [ADDR_W-1:0]      w_addr,
  output logic [CH_W-1:0]        w_len,
  input  logic                   w_ack,
  input  logic                   w_we,
  input  logic [DATA_W-1:0]      w_data,
  output logic                   vec_valid,
  input  logic                   vec_ready,
  output logic [PARA*DATA_W-1:0] vec_data,
  output logic [PARA*DATA_W-1:0] vec_weight,
  output logic [PARA-1:0]        vec_mask,
  output logic                   vec_first,
  output logic                   vec_last,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [2:0] {IDLE, CHECK, CALC, REQ, FILL, PRESENT, DONE} state_t;

  state_t                 r_state;
  logic [SIDE_W-1:0]      r_k, r_w, r_o, r_oy, r_ox, r_ky, r_kx;
  logic [3:0]             r_s;
  logic [1:0]             r_p;
  logic [CH_W-1:0]        r_c, r_m, r_oc, r_g, r_len, r_dcnt, r_wcnt;
  logic [ADDR_W-1:0]      r_dbase, r_wbase, r_d_addr, r_w_addr;
  logic                   r_d_req, r_w_req, r_valid, r_first, r_last, r_done, r_err;
  logic [PARA*DATA_W-1:0] r_dbuf, r_wbuf;
  logic [PARA-1:0]        r_mask;

  logic [31:0]     w_gbase, w_rem, w_iy, w_ix, w_daddr, w_waddr;
  logic [CH_W-1:0] w_lanes;
  logic [PARA-1:0] w_mask;
  logic            w_last_g, w_last_k, w_pad_tap, w_last_tap, w_cfg_bad;

  always_comb begin
    w_gbase = 32'(r_g) * 32'(PARA);
    w_rem   = 32'(r_c) - w_gbase;
    w_lanes = (w_rem >= 32'(PARA)) ? CH_W'(PARA) : CH_W'(w_rem);
    w_mask  = '0;
    for (int i = 0; i < PARA; i++) w_mask[i] = (CH_W'(i) < w_lanes);
    w_last_g = (w_gbase + 32'(PARA)) >= 32'(r_c);
    w_last_k = (r_ky == r_k - SIDE_W'(1)) && (r_kx == r_k - SIDE_W'(1));
    w_iy = 32'(r_oy) * 32'(r_s) + 32'(r_ky) - 32'(r_p);
    w_ix = 32'(r_ox) * 32'(r_s) + 32'(r_kx) - 32'(r_p);
    // A negative coordinate wraps to a huge unsigned value, so one compare covers both borders.
    w_pad_tap = (w_iy >= 32'(r_w)) || (w_ix >= 32'(r_w));
    w_daddr = 32'(r_dbase) + (w_iy * 32'(r_w) + w_ix) * 32'(r_c) + w_gbase;
    w_waddr = 32'(r_wbase) + ((32'(r_oc) * 32'(r_k) + 32'(r_ky)) * 32'(r_k) + 32'(r_kx))
              * 32'(r_c) + w_gbase;
    w_last_tap = w_last_k && w_last_g && (r_ox == r_o - SIDE_W'(1)) &&
                 (r_oy == r_o - SIDE_W'(1)) && (r_oc == r_m - CH_W'(1));
    w_cfg_bad = (r_k == '0) || (r_s == '0) || (r_c == '0) || (r_m == '0) || (r_o == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_k <= '0; r_w <= '0; r_o <= '0; r_s <= '0; r_p <= '0; r_c <= '0; r_m <= '0;
      r_dbase <= '0; r_wbase <= '0;
      r_oc <= '0; r_oy <= '0; r_ox <= '0; r_g <= '0; r_ky <= '0; r_kx <= '0;
      r_len <= '0; r_dcnt <= '0; r_wcnt <= '0; r_mask <= '0;
      r_d_addr <= '0; r_w_addr <= '0; r_d_req <= 1'b0; r_w_req <= 1'b0;
      r_valid <= 1'b0; r_first <= 1'b0; r_last <= 1'b0; r_done <= 1'b0; r_err <= 1'b0;
      r_dbuf <= '0; r_wbuf <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_k <= kernel; r_s <= stride; r_p <= pad; r_c <= i_channel; r_m <= o_channel;
          r_w <= i_side; r_o <= o_side; r_dbase <= data_base; r_wbase <= weight_base;
          r_err   <= 1'b0;
          r_state <= CHECK;
        end
        CHECK: if (w_cfg_bad) begin
          r_err <= 1'b1; r_done <= 1'b1; r_state <= DONE;
        end else begin
          r_oc <= '0; r_oy <= '0; r_ox <= '0; r_g <= '0; r_ky <= '0; r_kx <= '0;
          r_state <= CALC;
        end
        CALC: begin
          r_d_addr <= ADDR_W'(w_daddr);
          r_w_addr <= ADDR_W'(w_waddr);
          r_len    <= w_lanes;
          r_mask   <= w_mask;
          r_first  <= (r_g == '0) && (r_ky == '0) && (r_kx == '0);
          r_last   <= w_last_g && w_last_k;
          r_dbuf   <= '0;
          r_wbuf   <= '0;
          r_dcnt   <= w_pad_tap ? w_lanes : '0;  // padded data counts as already complete
          r_wcnt   <= '0;
          r_w_req  <= 1'b1;
          r_d_req  <= ~w_pad_tap;
          r_state  <= REQ;
        end
        REQ: begin
          if (r_w_req && w_ack) r_w_req <= 1'b0;
          if (r_d_req && d_ack) r_d_req <= 1'b0;
          if (!(r_w_req && !w_ack) && !(r_d_req && !d_ack)) r_state <= FILL;
        end
        FILL: begin
          if (d_we && (r_dcnt < r_len)) begin
            for (int i = 0; i < PARA; i++)
              if (r_dcnt == CH_W'(i)) r_dbuf[i*DATA_W +: DATA_W] <= d_data;
            r_dcnt <= r_dcnt + CH_W'(1);
          end
          if (w_we && (r_wcnt < r_len)) begin
            for (int i = 0; i < PARA; i++)
              if (r_wcnt == CH_W'(i)) r_wbuf[i*DATA_W +: DATA_W] <= w_data;
            r_wcnt <= r_wcnt + CH_W'(1);
          end
          if ((r_dcnt == r_len) && (r_wcnt == r_len)) begin
            r_valid <= 1'b1;
            r_state <= PRESENT;
          end
        end
        PRESENT: if (vec_ready) begin
          r_valid <= 1'b0;
          if (w_last_tap) begin
            r_done <= 1'b1; r_state <= DONE;
          end else begin
            r_state <= CALC;
            if (r_kx != r_k - SIDE_W'(1)) r_kx <= r_kx + SIDE_W'(1);
            else begin
              r_kx <= '0;
              if (r_ky != r_k - SIDE_W'(1)) r_ky <= r_ky + SIDE_W'(1);
              else begin
                r_ky <= '0;
                if (!w_last_g) r_g <= r_g + CH_W'(1);
                else begin
                  r_g <= '0;
                  if (r_ox != r_o - SIDE_W'(1)) r_ox <= r_ox + SIDE_W'(1);
                  else begin
                    r_ox <= '0;
                    if (r_oy != r_o - SIDE_W'(1)) r_oy <= r_oy + SIDE_W'(1);
                    else begin
                      r_oy <= '0;
                      r_oc <= r_oc + CH_W'(1);
                    end
                  end
                end
              end
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign d_req      = r_d_req;
  assign d_addr     = r_d_addr;
  assign d_len      = r_len;
  assign w_req      = r_w_req;
  assign w_addr     = r_w_addr;
  assign w_len      = r_len;
  assign vec_valid  = r_valid;
  assign vec_data   = r_dbuf;
  assign vec_weight = r_wbuf;
  assign vec_mask   = r_mask;
  assign vec_first  = r_first;
  assign vec_last   = r_last;
  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: doc/conv_fetch_seq.md
Name: conv_fetch_seq

Overview:
Parametrised convolution fetch sequencer that replaces the hard-wired 16-lane data/weight deserializer path of the convolution engine. It walks the output-channel, output-pixel, channel-group and kernel-tap loops of one conv layer and issues one data burst and one weight burst per tap. It deserializes both DMA return streams into PARA-lane vectors and hands each vector pair to the CMAC array over a valid/ready handshake. New relative to the fixed-16 engine: arbitrary PARA, channel-remainder groups with a lane mask, stride, and zero padding without DMA traffic.

Parameters:
DATA_W, 16, element width (fp16)
PARA, 16, lanes per vector (2..64)
ADDR_W, 30, DMA word address width
SIDE_W, 8, width of side/kernel fields
CH_W, 16, width of channel fields

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle layer start pulse, sampled only in IDLE
kernel  in  SIDE_W  kernel side K (1..)
stride  in  4  stride S (1..)
pad  in  2  zero-pad pixels P on each border
i_channel  in  CH_W  input channels C
o_channel  in  CH_W  output channels M
i_side  in  SIDE_W  input side W
o_side  in  SIDE_W  output side O
data_base  in  ADDR_W  HWC input base
weight_base  in  ADDR_W  [M][K][K][C] weight base
d_req / w_req  out  1  burst request, held until ack
d_addr / w_addr  out  ADDR_W  burst start address
d_len / w_len  out  CH_W  burst length in words (= group lanes)
d_ack / w_ack  in  1  request accepted
d_we / w_we  in  1  return word strobe
d_data / w_data  in  DATA_W  return word
vec_valid  out  1  vector pair available
vec_ready  in  1  consumer accepts
vec_data  out  PARA*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
vec_weight  out  PARA*DATA_W  same layout
vec_mask  out  PARA  valid-lane mask
vec_first  out  1  first tap of first group of a pixel (clear accumulator)
vec_last  out  1  last tap of last group of a pixel (pixel complete)
busy  out  1  not IDLE
done  out  1  one-cycle pulse at layer end
err  out  1  config error, sticky until next start

Behaviour:
- Reset: state IDLE, all outputs 0, vec buffers 0, loop counters 0.
- Loop order, outer to inner: oc (0..M-1), oy, ox (0..O-1), g (channel group), ky, kx (0..K-1).
- Group g covers channels g*PARA .. min(C, (g+1)*PARA)-1. Lanes L = min(PARA, C - g*PARA).
- vec_mask = (1<<L)-1. Lanes >= L are driven 0.
- Input coordinates: iy = oy*S + ky - P, ix = ox*S + kx - P, computed signed.
- Tap is padded if iy<0, ix<0, iy>=W or ix>=W.
- d_addr = data_base + (iy*W + ix)*C + g*PARA.
- w_addr = weight_base + ((oc*K + ky)*K + kx)*C + g*PARA.
- Address arithmetic is at least 32 bits, truncated to ADDR_W. No overflow detection.
- States: IDLE, CHECK, CALC, REQ, FILL, PRESENT, DONE.
- IDLE --start--> CHECK.
- CHECK: if K==0, S==0, C==0, M==0 or O==0, set err and go to DONE. Otherwise go to CALC with counters cleared. Err is cleared on start.
- CALC (1 cycle): latch addresses, L and the pad flag, then go to REQ.
- REQ: assert w_req always. Assert d_req only if not padded.
  - Each req drops the cycle after its ack; req and ack may coincide in the same cycle.
  - Go to FILL once every issued request has been acked.
- FILL: each d_we/w_we writes lane beat_cnt of its buffer, then beat_cnt increments. Independent counters per stream.
  - A padded tap's data buffer is zero-filled in CALC and its data stream is not waited on.
  - Go to PRESENT when both streams have received L beats.
  - Beats beyond L, or strobes outside FILL, are dropped.
- PRESENT: vec_valid=1 with data, weight, mask, first and last stable until vec_ready. Vector accepted on valid && ready.
  - After accept: if the innermost tap was the last of the whole layer, go to DONE, otherwise advance counters and go to CALC.
  - Minimum 3 cycles from accept to next vec_valid.
- vec_first = (g==0 && ky==0 && kx==0). vec_last = (last g && ky==K-1 && kx==K-1).
- DONE: done=1 for one cycle, then IDLE. busy=0 only in IDLE.
- start while not IDLE is ignored. Config inputs are sampled at start and held internally.
- rst mid-layer returns to IDLE immediately. Outstanding DMA returns after reset are dropped.

Test Plan:
- K=1,S=1,P=0,C=16,M=1,W=O=2, PARA=16 -> exactly 4 vectors. d_addr 0,16,32,48 (+base). vec_first=vec_last=1 on each. Mask 0xFFFF. done after the 4th accept.
- C=20, PARA=16, K=1 -> per pixel, group 0 has mask 0xFFFF and len 16, group 1 has mask 0x000F and len 4. Lanes 4..15 read 0. vec_last only on group 1.
- K=3,P=1,S=1,W=O=4,C=16 -> pixel (0,0) has 5 padded taps: no d_req, vec_data all 0, w_req still issued. 9 vectors for the pixel.
- K=3,S=2,P=0,W=5,O=2,C=16,M=2 -> 72 vectors total. First tap of ox=1 has d_addr = base+32. oc=1 w_addr starts at weight_base+144.
- vec_ready held low 10 cycles in PRESENT, with d_we and w_we burst beats injected meanwhile -> vec_data/vec_weight unchanged, extra beats dropped.
- K=0 -> err=1, done pulse 2 cycles after start, no req. rst asserted mid-FILL -> all outputs 0 and IDLE within the same cycle.
